// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-N up/down counter with LS163 controls, load clamp and registered wrap pulse.
// Define UDCNT_SATURATE_EN to hold at the terminal count instead of wrapping.
module mod_updown_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_n,
   input  logic             load_n,
   input  logic             ent,
   input  logic             enp,
   input  logic             up,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             rco,
   output logic             wrap
);
   if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_param
      $error("mod_updown_counter: MODULUS must be 2..2**WIDTH and WIDTH 1..32");
   end
   localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MODULUS - 1);
   logic [WIDTH:0]   qx, inc, dec;
   logic [WIDTH-1:0] q_nxt, ld;
   logic             at_term, wrap_nxt;
   assign qx      = {1'b0, q};
   assign inc     = qx + 1'b1;
   assign dec     = qx - 1'b1;
   assign at_term = up ? (qx == MAXV) : (q == '0);
   assign rco     = ent && at_term;
   assign ld      = ({1'b0, din} > MAXV) ? MAXV[WIDTH-1:0] : din;
   always_comb begin
      q_nxt    = q;
      wrap_nxt = 1'b0;
      if (!clear_n) q_nxt = '0;
      else if (!load_n) q_nxt = ld;
      else if (ent && enp) begin
`ifdef UDCNT_SATURATE_EN
         q_nxt = at_term ? q : (up ? inc[WIDTH-1:0] : dec[WIDTH-1:0]);
`else
         q_nxt    = at_term ? (up ? '0 : MAXV[WIDTH-1:0]) : (up ? inc[WIDTH-1:0] : dec[WIDTH-1:0]);
         wrap_nxt = at_term;
`endif
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         q    <= '0;
         wrap <= 1'b0;
      end else begin
         q    <= q_nxt;
         wrap <= wrap_nxt;
      end
   end
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: vector table plus scoreboard queue for mod_updown_counter (WIDTH=4, MODULUS=10).
module tb_mod_updown_counter;
   typedef struct {
      logic       rst, clr_n, ld_n, ent, enp, up;
      logic [3:0] din;
      logic [3:0] q;
      logic       rco, wrap;
   } vec_t;
   typedef struct {
      logic [3:0] q;
      logic       rco, wrap;
   } exp_t;

   logic       clk = 1'b0, reset, clear_n, load_n, ent, enp, up;
   logic [3:0] din, q;
   logic       rco, wrap;
   int         checks = 0, failures = 0;
   vec_t       vecs[$];
   exp_t       sb[$];

   mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .clk(clk), .reset(reset), .clear_n(clear_n), .load_n(load_n), .ent(ent), .enp(enp),
      .up(up), .din(din), .q(q), .rco(rco), .wrap(wrap)
   );

   always #50 clk = ~clk;

   function automatic vec_t mk(logic rst, logic clr_n, logic ld_n, logic e_t, logic e_p, logic u,
                               logic [3:0] d, logic [3:0] eq, logic er, logic ew);
      vec_t v;
      v.rst = rst; v.clr_n = clr_n; v.ld_n = ld_n; v.ent = e_t; v.enp = e_p; v.up = u;
      v.din = d; v.q = eq; v.rco = er; v.wrap = ew;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      reset = v.rst; clear_n = v.clr_n; load_n = v.ld_n; ent = v.ent; enp = v.enp; up = v.up; din = v.din;
   endtask

   task automatic step(input vec_t v, input string name);
      exp_t e;
      drive(v);
      e.q = v.q; e.rco = v.rco; e.wrap = v.wrap;
      sb.push_back(e);
      @(posedge clk);
      #10;
      if (sb.size() == 0) begin
         checks++; failures++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         chk({name, ".q"}, q, e.q);
         chk({name, ".rco"}, rco, e.rco);
         chk({name, ".wrap"}, wrap, e.wrap);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // reset with a pending load and ent=0
      vecs.push_back(mk(1, 1, 0, 0, 0, 1, 4'd7, 4'd0, 0, 0));
      for (int i = 1; i <= 10; i++)
         vecs.push_back(mk(0, 1, 1, 1, 1, 1, 4'd0, 4'(i % 10), i == 9, i == 10));
      for (int i = 0; i <= 10; i++)
         vecs.push_back(mk(0, 1, 1, 1, 1, 0, 4'd0, (i == 10) ? 4'd9 : 4'(9 - i), i == 9, i == 0 || i == 10));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 4'd0, 4'd9, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 4'd0, 4'd9, 1, 0));

      reset = 1; clear_n = 1; load_n = 1; ent = 0; enp = 0; up = 1; din = 0;
      foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

      // rco is combinational on ent and up: no clock edge in between
      ent = 0; #10;
      chk("rco_ent_low", rco, 0);
      chk("hold_q", q, 9);
      ent = 1; #10;
      chk("rco_ent_high", rco, 1);
      up = 0; #10;
      chk("rco_dir_down", rco, 0);
      up = 1;
      @(negedge clk);

      // load takes effect at the edge, not before
      drive(mk(0, 1, 0, 1, 1, 1, 4'd6, 4'd0, 0, 0)); #10;
      chk("load_not_before", q, 9);
      step(mk(0, 1, 0, 1, 1, 1, 4'd6, 4'd6, 0, 0), "load6");
      step(mk(0, 1, 0, 1, 1, 1, 4'd13, 4'd9, 1, 0), "load13_clamp");
      step(mk(0, 0, 0, 1, 1, 1, 4'd5, 4'd0, 0, 0), "clear_over_load");

      step(mk(0, 1, 0, 0, 0, 1, 4'd8, 4'd8, 0, 0), "load8");
      step(mk(0, 1, 1, 1, 1, 1, 4'd0, 4'd9, 1, 0), "up_to9");
`ifdef UDCNT_SATURATE_EN
      step(mk(0, 1, 1, 1, 1, 1, 4'd0, 4'd9, 1, 0), "sat_hold1");
      step(mk(0, 1, 1, 1, 1, 1, 4'd0, 4'd9, 1, 0), "sat_hold2");
      step(mk(0, 1, 1, 1, 1, 0, 4'd0, 4'd8, 0, 0), "sat_down");
`else
      step(mk(0, 1, 1, 1, 1, 1, 4'd0, 4'd0, 0, 1), "wrap_up");
      step(mk(0, 1, 1, 1, 1, 1, 4'd0, 4'd1, 0, 0), "after_wrap");
      step(mk(0, 1, 1, 1, 1, 0, 4'd0, 4'd0, 1, 0), "dir_change");
`endif
      step(mk(0, 1, 0, 1, 1, 1, 4'd9, 4'd9, 1, 0), "load9");
      // reset at terminal count cancels the wrap that counting would produce
      step(mk(1, 1, 1, 1, 1, 1, 4'd0, 4'd0, 0, 0), "reset_mid_count");
      step(mk(0, 1, 1, 1, 1, 1, 4'd0, 4'd1, 0, 0), "count_after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
